// File: rtl/simon_pkg.sv
// simon_pkg: shared state codes, LFSR taps and default timing for the Simon controller.
package simon_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GEN      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        WAIT_IN  = 3'd4,
        WIN      = 3'd5,
        LOSE     = 3'd6
    } state_t;
    localparam int LFSR_W = 16;
    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam int DEF_FLASH_ON   = 25_000_000;
    localparam int DEF_GAP        = 12_500_000;
    localparam int DEF_TIMEOUT    = 250_000_000;
    localparam int DEF_RESULT_CYC = 100_000_000;
endpackage

// File: rtl/simon_core_param_if.sv
// simon_core_param_if: button/LED/score bundle between the Simon core and its surroundings.
interface simon_core_param_if #(parameter int NUM_BTN = 4);
    logic               start;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] led_out;
    logic [2:0]         state_o;
    logic [6:0]         round_len;
    logic [6:0]         score;
    logic [6:0]         best_score;
    logic               win;
    logic               lose;
    logic               busy;
    modport master (
        output start, btn_press,
        input  led_out, state_o, round_len, score, best_score, win, lose, busy
    );
    modport slave (
        input  start, btn_press,
        output led_out, state_o, round_len, score, best_score, win, lose, busy
    );
endinterface

// File: rtl/simon_lfsr.sv
// simon_lfsr: free-running Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter int             W     = LFSR_W,
    parameter logic [W-1:0]   TAPS  = LFSR_TAPS,
    parameter logic [W-1:0]   SEED  = 16'hACE1,
    parameter int             OUT_W = W
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] q
);
    localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;
    logic [W-1:0] r;
    always_ff @(posedge clk) begin
        if (!rst_n) r <= INIT;
        else        r <= (r >> 1) ^ (r[0] ? TAPS : '0);
    end
    assign q = r[OUT_W-1:0];
endmodule

// File: rtl/simon_core_param.sv
// simon_core_param: N-button Simon game FSM with replay, timed echo input and score tracking.
module simon_core_param
    import simon_pkg::*;
#(
    parameter int          NUM_BTN    = 4,
    parameter int          MAX_LEN    = 16,
    parameter int          FLASH_ON   = DEF_FLASH_ON,
    parameter int          GAP        = DEF_GAP,
    parameter int          TIMEOUT    = DEF_TIMEOUT,
    parameter int          RESULT_CYC = DEF_RESULT_CYC,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    simon_core_param_if.slave    bus
);
    localparam int SYM_W = $clog2(NUM_BTN);
    localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int M1    = (FLASH_ON > GAP) ? FLASH_ON : GAP;
    localparam int M2    = (TIMEOUT > RESULT_CYC) ? TIMEOUT : RESULT_CYC;
    localparam int MAXC  = (M1 > M2) ? M1 : M2;
    localparam int CW    = $clog2(MAXC + 1);

    state_t             state;
    logic [NUM_BTN-1:0] led;
    logic [6:0]         rlen, score_r, best_r, idx, nidx;
    logic [CW-1:0]      cnt;
    logic [SYM_W-1:0]   raw, sym;
    logic [SYM_W-1:0]   seq [MAX_LEN];

    function automatic logic [NUM_BTN-1:0] onehot(input logic [SYM_W-1:0] s);
        return {{(NUM_BTN-1){1'b0}}, 1'b1} << s;
    endfunction

    simon_lfsr #(.SEED(SEED), .OUT_W(SYM_W)) u_lfsr (.clk(clk), .rst_n(rst_n), .q(raw));

    // Fold out-of-range codes back so non-power-of-two button counts stay uniform-ish
    assign sym  = ({1'b0, raw} >= (SYM_W+1)'(NUM_BTN)) ? raw - SYM_W'(NUM_BTN) : raw;
    assign nidx = idx + 7'd1;

    // idx doubles as the replay index and the echo-check index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            led    <= '0;
            rlen   <= '0;
            score_r <= '0;
            best_r <= '0;
            idx    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state   <= GEN;
                    rlen    <= '0;
                    score_r <= '0;
                end
                GEN: begin
                    seq[rlen[IW-1:0]] <= sym;
                    rlen  <= rlen + 7'd1;
                    idx   <= '0;
                    cnt   <= '0;
                    led   <= onehot((rlen == '0) ? sym : seq[0]);
                    state <= SHOW_ON;
                end
                SHOW_ON: if (cnt == CW'(FLASH_ON - 1)) begin
                    cnt   <= '0;
                    led   <= '0;
                    state <= SHOW_OFF;
                end else cnt <= cnt + 1'b1;
                SHOW_OFF: if (cnt == CW'(GAP - 1)) begin
                    cnt <= '0;
                    if (idx == rlen - 7'd1) begin
                        idx   <= '0;
                        state <= WAIT_IN;
                    end else begin
                        idx   <= nidx;
                        led   <= onehot(seq[nidx[IW-1:0]]);
                        state <= SHOW_ON;
                    end
                end else cnt <= cnt + 1'b1;
                WAIT_IN: begin
                    led <= bus.btn_press;
                    if (bus.btn_press == '0) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(TIMEOUT - 1)) begin
                            cnt   <= '0;
                            state <= LOSE;
                        end
                    end else if (bus.btn_press != onehot(seq[idx[IW-1:0]])) begin
                        led   <= '0;
                        cnt   <= '0;
                        state <= LOSE;
                    end else if (idx != rlen - 7'd1) begin
                        idx <= nidx;
                        cnt <= '0;
                    end else begin
                        cnt     <= '0;
                        score_r <= rlen;
                        best_r  <= (rlen > best_r) ? rlen : best_r;
                        led     <= (rlen == 7'(MAX_LEN)) ? '1 : bus.btn_press;
                        state   <= (rlen == 7'(MAX_LEN)) ? WIN : GEN;
                    end
                end
                WIN, LOSE: if (cnt == CW'(RESULT_CYC - 1)) begin
                    cnt   <= '0;
                    led   <= '0;
                    state <= IDLE;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led_out    = led;
    assign bus.state_o    = state;
    assign bus.round_len  = rlen;
    assign bus.score      = score_r;
    assign bus.best_score = best_r;
    assign bus.win        = (state == WIN);
    assign bus.lose       = (state == LOSE);
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_simon_core_param.sv
// tb_simon_core_param: directed game scenarios; the sequence is learned from the replay LEDs.
module tb_simon_core_param;
    localparam int NB = 4, ML = 3, FO = 4, GP = 2, TO = 20, RC = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0, bad = 0;
    int s [ML];

    simon_core_param_if #(.NUM_BTN(NB)) bus();
    simon_core_param #(
        .NUM_BTN(NB), .MAX_LEN(ML), .FLASH_ON(FO), .GAP(GP),
        .TIMEOUT(TO), .RESULT_CYC(RC), .SEED(16'hACE1)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    task automatic start_game;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("gen_state", 32'(bus.state_o), 1);
        check("gen_busy", 32'(bus.busy), 1);
        check("gen_len", 32'(bus.round_len), 0);
    endtask

    // Starts at the GEN-cycle negedge, ends at the first WAIT_IN negedge
    task automatic watch(input int r, input bit noise);
        int j;
        for (int k = 0; k < r; k++) begin
            for (int c = 0; c < FO + GP; c++) begin
                tick;
                if (c < FO) begin
                    check("show_on_state", 32'(bus.state_o), 2);
                    if (c == 0) begin
                        j = -1;
                        for (int b = 0; b < NB; b++) if (32'(bus.led_out) == oh(b)) j = b;
                        check("show_onehot", 32'(j >= 0), 1);
                        if (k < r - 1) check("seq_keep", j, s[k]);
                        else s[k] = (j < 0) ? 0 : j;
                        if (k == 0) check("show_len", 32'(bus.round_len), r);
                    end
                    check("show_on_led", 32'(bus.led_out), oh(s[k]));
                end else begin
                    check("show_off_state", 32'(bus.state_o), 3);
                    check("show_off_led", 32'(bus.led_out), 0);
                end
                if (noise) begin
                    bus.btn_press = NB'(oh(c % NB));
                    bus.start = (c % 2 == 0);
                end
            end
        end
        bus.btn_press = '0;
        bus.start = 1'b0;
        tick;
        check("wait_state", 32'(bus.state_o), 4);
        check("wait_led", 32'(bus.led_out), 0);
    endtask

    task automatic echo(input int r);
        for (int i = 0; i < r; i++) begin
            bus.btn_press = NB'(oh(s[i]));
            tick;
            bus.btn_press = '0;
            if (i < r - 1) begin
                check("echo_state", 32'(bus.state_o), 4);
                check("echo_led", 32'(bus.led_out), oh(s[i]));
            end
        end
        check("round_score", 32'(bus.score), r);
    endtask

    // Starts at the first WIN/LOSE negedge, ends at the first IDLE negedge
    task automatic hold(input int st);
        for (int i = 0; i < RC; i++) begin
            check("res_state", 32'(bus.state_o), st);
            check("res_win", 32'(bus.win), 32'(st == 5));
            check("res_lose", 32'(bus.lose), 32'(st == 6));
            check("res_led", 32'(bus.led_out), (st == 5) ? 32'hF : 32'h0);
            tick;
        end
        check("res_idle", 32'(bus.state_o), 0);
        check("res_busy", 32'(bus.busy), 0);
    endtask

    task automatic reset_checks;
        check("rst_state", 32'(bus.state_o), 0);
        check("rst_led", 32'(bus.led_out), 0);
        check("rst_len", 32'(bus.round_len), 0);
        check("rst_score", 32'(bus.score), 0);
        check("rst_best", 32'(bus.best_score), 0);
        check("rst_win", 32'(bus.win), 0);
        check("rst_lose", 32'(bus.lose), 0);
        check("rst_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.btn_press = '0;
        repeat (3) tick;
        reset_checks();
        rst_n = 1'b1;
        tick;
        // Full three-round win
        start_game();
        watch(1, 1'b0); echo(1);
        check("r1_next", 32'(bus.state_o), 1);
        check("r1_best", 32'(bus.best_score), 1);
        watch(2, 1'b0); echo(2);
        check("r2_next", 32'(bus.state_o), 1);
        watch(3, 1'b0); echo(3);
        check("win_best", 32'(bus.best_score), 3);
        hold(5);
        // Wrong second symbol in round 2
        start_game();
        check("restart_score", 32'(bus.score), 0);
        watch(1, 1'b0); echo(1);
        watch(2, 1'b0);
        bus.btn_press = NB'(oh(s[0]));
        tick;
        bus.btn_press = NB'(oh((s[1] + 1) % NB));
        tick;
        bus.btn_press = '0;
        check("wrong_score", 32'(bus.score), 1);
        check("wrong_best", 32'(bus.best_score), 3);
        hold(6);
        // Two buttons at once
        start_game();
        watch(1, 1'b0);
        bus.btn_press = 4'b0011;
        tick;
        bus.btn_press = '0;
        hold(6);
        // Timeout with no press
        start_game();
        watch(1, 1'b0);
        repeat (TO - 1) begin tick; check("to_wait", 32'(bus.state_o), 4); end
        tick;
        hold(6);
        // Press on the last allowed cycle, with replay noise ignored
        start_game();
        watch(1, 1'b1); echo(1);
        watch(2, 1'b1);
        repeat (TO - 1) begin tick; check("late_wait", 32'(bus.state_o), 4); end
        bus.btn_press = NB'(oh(s[0]));
        tick;
        bus.btn_press = '0;
        check("late_alive", 32'(bus.state_o), 4);
        check("late_echo", 32'(bus.led_out), oh(s[0]));
        repeat (TO - 1) begin tick; check("late_wait2", 32'(bus.state_o), 4); end
        bus.btn_press = NB'(oh(s[1]));
        tick;
        bus.btn_press = '0;
        check("late_next", 32'(bus.state_o), 1);
        check("late_score", 32'(bus.score), 2);
        watch(3, 1'b0); echo(3);
        hold(5);
        // Reset mid-replay of round 2 clears best_score too
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("rst2_best", 32'(bus.best_score), 0);
        start_game();
        watch(1, 1'b0); echo(1);
        check("pre_rst_best", 32'(bus.best_score), 1);
        tick; tick;
        check("pre_rst_state", 32'(bus.state_o), 2);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        reset_checks();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/simon_core_param.md
Name: simon_core_param

Overview:
- Parametrised successor to the two-button Simon controller.
- Plays a true Simon game: each round appends one random symbol and replays the whole sequence on NUM_BTN LEDs. The player must then echo the sequence.
- New over the previous generation: N channels, configurable maximum length, a per-press input timeout, multi-press detection, and current/best score reporting.
- Sits between the button debouncers (single-cycle press pulses) and the LED/7-seg display logic.

Parameters:
- NUM_BTN, 4, number of buttons/LEDs (2..8).
- MAX_LEN, 16, winning sequence length (1..64).
- FLASH_ON, 25_000_000, cycles each symbol LED is lit.
- GAP, 12_500_000, cycles all LEDs are dark after each symbol.
- TIMEOUT, 250_000_000, cycles allowed between presses in WAIT_IN.
- RESULT_CYC, 100_000_000, cycles the WIN/LOSE state is held.
- SEED, 16'hACE1, LFSR reset value; 0 is forced to 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; begins a game.
- btn_press  in  NUM_BTN  debounced single-cycle press pulses, bit i = button i.
- led_out  out  NUM_BTN  LED drive.
- state_o  out  3  current FSM state code (debug LEDs).
- round_len  out  7  current sequence length.
- score  out  7  last fully completed round length this game.
- best_score  out  7  maximum score since reset.
- win  out  1  high throughout WIN.
- lose  out  1  high throughout LOSE.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 sampled at posedge, any state):
  - FSM to IDLE.
  - led_out, round_len, score, best_score, win, lose, busy all 0.
  - LFSR loaded with SEED.
  - Sequence RAM contents are don't-care.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle including IDLE, so the player's start timing seeds the game.
- Symbol generation:
  - sym = lfsr[SYM_W-1:0], where SYM_W = clog2(NUM_BTN).
  - If sym >= NUM_BTN, sym = sym - NUM_BTN.
- State codes: IDLE=0, GEN=1, SHOW_ON=2, SHOW_OFF=3, WAIT_IN=4, WIN=5, LOSE=6.
- IDLE:
  - start -> GEN; round_len=0; score=0.
  - btn_press ignored.
- GEN (1 cycle):
  - seq[round_len] = sym; round_len += 1; show index = 0.
  - -> SHOW_ON.
- SHOW_ON:
  - led_out = one-hot(seq[idx]) for exactly FLASH_ON cycles.
  - -> SHOW_OFF.
- SHOW_OFF:
  - led_out = 0 for GAP cycles.
  - If idx == round_len-1 -> WAIT_IN, with check index = 0 and timeout counter cleared.
  - Otherwise idx += 1 and -> SHOW_ON.
- WAIT_IN:
  - led_out mirrors btn_press (1-cycle echo).
  - btn_press == 0: timeout counter += 1. When it reaches TIMEOUT -> LOSE.
  - More than one bit set: LOSE.
  - One-hot press not equal to seq[chk]: LOSE.
  - Correct press with chk < round_len-1: chk += 1; timeout counter cleared.
  - Correct press with chk == round_len-1: score = round_len; best_score = max(best_score, round_len). Then -> WIN if round_len == MAX_LEN, else -> GEN.
- WIN: led_out all ones, win=1 for RESULT_CYC cycles, then -> IDLE.
- LOSE: led_out = 0, lose=1 for RESULT_CYC cycles, then -> IDLE.
- Ignored inputs:
  - start outside IDLE.
  - btn_press outside WAIT_IN; presses during the replay are not buffered.
- Counters and registers:
  - All cycle counters are wide enough for the largest parameter. No wrap before terminal count.
  - round_len never exceeds MAX_LEN.
  - state_o, score and best_score are registered outputs.
  - busy = (state != IDLE).
- Timing: start pulse in IDLE at cycle t gives GEN at t+1 and SHOW_ON at t+2. A replay of length r lasts r*(FLASH_ON+GAP) cycles.
- Simultaneous events: in WAIT_IN, a press on the same cycle the timeout counter reaches TIMEOUT is evaluated as a press; the timeout loses.

Decomposition:
- Package simon_pkg holds:
  - state enum (3-bit codes above);
  - LFSR tap constant;
  - default timing constants.
- SYM_W and counter widths are local params derived in the module.
- One sub-module, simon_lfsr (width, taps, seed, enable-free). Sequence storage is an inline register array.

Test Plan:
All scenarios use NUM_BTN=4, MAX_LEN=3, FLASH_ON=4, GAP=2, TIMEOUT=20, RESULT_CYC=5. The bench learns the sequence by sampling led_out during SHOW_ON.
1. Full win: start at t -> led_out one-hot during t+2..t+5, 0 during t+6..t+7, state_o=4 at t+8. Echo the correct symbols for rounds 1-3 -> win=1 for 5 cycles, score=3, best_score=3, then state_o=0.
2. Wrong button in round 2, second symbol -> next cycle state_o=6, lose=1 for 5 cycles, score=1, led_out=0.
3. Timeout: reach WAIT_IN, press nothing -> state_o=6 exactly 20 cycles after entering WAIT_IN. A correct press at cycle 19 instead clears the counter and no loss occurs.
4. Two buttons pressed in the same cycle (btn_press=4'b0011) in WAIT_IN -> LOSE.
5. Presses and a second start pulse during SHOW_ON/SHOW_OFF -> ignored: sequence progress, score and state unchanged.
6. rst_n low for one cycle mid-SHOW_ON of round 2, with best_score=1 beforehand -> next cycle state_o=0 and all outputs 0, including best_score.
